// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges the integer (ip), load/store (lsp) and mul/div (md)
// completion streams into one register-file write port plus a retire trace.
// ip has priority unless lsp or md has been starved for STARVE_LIMIT cycles;
// lsp and md share round-robin. Outputs are registered one cycle after transfer.
module wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,

  input  logic [4:0]  ip_wb_dst,
  input  logic [63:0] ip_wb_result,
  input  logic [63:0] ip_wb_pc,
  input  logic        ip_wb_wb_en,
  input  logic        ip_wb_valid,
  output logic        ip_wb_ready,

  input  logic [4:0]  lsp_wb_dst,
  input  logic [63:0] lsp_wb_result,
  input  logic [63:0] lsp_wb_pc,
  input  logic        lsp_wb_wb_en,
  input  logic        lsp_wb_valid,
  output logic        lsp_wb_ready,

  input  logic [4:0]  md_wb_dst,
  input  logic [63:0] md_wb_result,
  input  logic [63:0] md_wb_pc,
  input  logic        md_wb_wb_en,
  input  logic        md_wb_valid,
  output logic        md_wb_ready,

  output logic        rf_wen,
  output logic [4:0]  rf_waddr,
  output logic [63:0] rf_wdata,

  output logic        wb_trace_valid,
  output logic [63:0] wb_trace_pc,
  output logic [63:0] wb_retire_count
);

  // Counter must hold the value STARVE_LIMIT itself; keep at least one bit.
  localparam int unsigned CntW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] Limit = CntW'(STARVE_LIMIT);

  logic [CntW-1:0] lsp_wait_q, lsp_wait_d;
  logic [CntW-1:0] md_wait_q, md_wait_d;
  logic            rr_lsp_q, rr_lsp_d;  // 1: lsp wins an lsp/md tie

  logic            ip_hold;
  logic            grant_ip, grant_lsp, grant_md, xfer;
  logic [4:0]      sel_dst;
  logic [63:0]     sel_result, sel_pc;
  logic            sel_wb_en;

  logic            rf_wen_q;
  logic [4:0]      rf_waddr_q;
  logic [63:0]     rf_wdata_q;
  logic            trace_valid_q;
  logic [63:0]     trace_pc_q;
  logic [63:0]     retire_q;

  // Grant decision: ip first unless a starved source forces a hold-off.
  always_comb begin
    ip_hold   = (lsp_wait_q == Limit) || (md_wait_q == Limit);
    grant_ip  = 1'b0;
    grant_lsp = 1'b0;
    grant_md  = 1'b0;
    if (!rst) begin
      if (ip_wb_valid && !ip_hold) begin
        grant_ip = 1'b1;
      end else if (lsp_wb_valid && (!md_wb_valid || rr_lsp_q)) begin
        grant_lsp = 1'b1;
      end else if (md_wb_valid) begin
        grant_md = 1'b1;
      end
    end
  end

  assign ip_wb_ready  = grant_ip;
  assign lsp_wb_ready = grant_lsp;
  assign md_wb_ready  = grant_md;
  assign xfer         = grant_ip | grant_lsp | grant_md;

  // Select the payload of the granted source.
  always_comb begin
    sel_dst    = ip_wb_dst;
    sel_result = ip_wb_result;
    sel_pc     = ip_wb_pc;
    sel_wb_en  = ip_wb_wb_en;
    if (grant_lsp) begin
      sel_dst    = lsp_wb_dst;
      sel_result = lsp_wb_result;
      sel_pc     = lsp_wb_pc;
      sel_wb_en  = lsp_wb_wb_en;
    end else if (grant_md) begin
      sel_dst    = md_wb_dst;
      sel_result = md_wb_result;
      sel_pc     = md_wb_pc;
      sel_wb_en  = md_wb_wb_en;
    end
  end

  // Starvation counters and round-robin pointer next state.
  always_comb begin
    if (!lsp_wb_valid || grant_lsp) begin
      lsp_wait_d = '0;
    end else if (lsp_wait_q != Limit) begin
      lsp_wait_d = lsp_wait_q + CntW'(1);
    end else begin
      lsp_wait_d = lsp_wait_q;
    end

    if (!md_wb_valid || grant_md) begin
      md_wait_d = '0;
    end else if (md_wait_q != Limit) begin
      md_wait_d = md_wait_q + CntW'(1);
    end else begin
      md_wait_d = md_wait_q;
    end

    rr_lsp_d = rr_lsp_q;
    if (grant_lsp) begin
      rr_lsp_d = 1'b0;
    end else if (grant_md) begin
      rr_lsp_d = 1'b1;
    end
  end

  // Arbitration state and registered writeback/trace outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      lsp_wait_q    <= '0;
      md_wait_q     <= '0;
      rr_lsp_q      <= 1'b1;
      rf_wen_q      <= 1'b0;
      rf_waddr_q    <= '0;
      rf_wdata_q    <= '0;
      trace_valid_q <= 1'b0;
      trace_pc_q    <= '0;
      retire_q      <= '0;
    end else begin
      lsp_wait_q    <= lsp_wait_d;
      md_wait_q     <= md_wait_d;
      rr_lsp_q      <= rr_lsp_d;
      rf_wen_q      <= xfer && sel_wb_en && (sel_dst != 5'd0);
      trace_valid_q <= xfer;
      if (xfer) begin
        rf_waddr_q <= sel_dst;
        rf_wdata_q <= sel_result;
        trace_pc_q <= sel_pc;
        retire_q   <= retire_q + 64'd1;
      end
    end
  end

  assign rf_wen          = rf_wen_q;
  assign rf_waddr        = rf_waddr_q;
  assign rf_wdata        = rf_wdata_q;
  assign wb_trace_valid  = trace_valid_q;
  assign wb_trace_pc     = trace_pc_q;
  assign wb_retire_count = retire_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: a reference model predicts grants and
// pushes expected writeback records to a queue, popped one cycle later.
module tb_wb_arbiter;

  localparam int unsigned Limit = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ip_wb_dst, lsp_wb_dst, md_wb_dst;
  logic [63:0] ip_wb_result, lsp_wb_result, md_wb_result;
  logic [63:0] ip_wb_pc, lsp_wb_pc, md_wb_pc;
  logic        ip_wb_wb_en, lsp_wb_wb_en, md_wb_wb_en;
  logic        ip_wb_valid, lsp_wb_valid, md_wb_valid;
  logic        ip_wb_ready, lsp_wb_ready, md_wb_ready;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic        wb_trace_valid;
  logic [63:0] wb_trace_pc;
  logic [63:0] wb_retire_count;

  wb_arbiter #(.STARVE_LIMIT(Limit)) dut (
    .clk             (clk),
    .rst             (rst),
    .ip_wb_dst       (ip_wb_dst),
    .ip_wb_result    (ip_wb_result),
    .ip_wb_pc        (ip_wb_pc),
    .ip_wb_wb_en     (ip_wb_wb_en),
    .ip_wb_valid     (ip_wb_valid),
    .ip_wb_ready     (ip_wb_ready),
    .lsp_wb_dst      (lsp_wb_dst),
    .lsp_wb_result   (lsp_wb_result),
    .lsp_wb_pc       (lsp_wb_pc),
    .lsp_wb_wb_en    (lsp_wb_wb_en),
    .lsp_wb_valid    (lsp_wb_valid),
    .lsp_wb_ready    (lsp_wb_ready),
    .md_wb_dst       (md_wb_dst),
    .md_wb_result    (md_wb_result),
    .md_wb_pc        (md_wb_pc),
    .md_wb_wb_en     (md_wb_wb_en),
    .md_wb_valid     (md_wb_valid),
    .md_wb_ready     (md_wb_ready),
    .rf_wen          (rf_wen),
    .rf_waddr        (rf_waddr),
    .rf_wdata        (rf_wdata),
    .wb_trace_valid  (wb_trace_valid),
    .wb_trace_pc     (wb_trace_pc),
    .wb_retire_count (wb_retire_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wen;
    logic [4:0]  waddr;
    logic [63:0] wdata;
    logic [63:0] pc;
  } wb_exp_t;

  wb_exp_t     exp_q[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model state
  int unsigned m_lsp_wait, m_md_wait;
  bit          m_rr_lsp;
  logic [63:0] m_count, m_wdata, m_pc;
  logic [4:0]  m_waddr;
  logic [2:0]  last_rdy;  // {ip, lsp, md} ready seen in the last cycle

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_lsp_wait = 0;
    m_md_wait  = 0;
    m_rr_lsp   = 1'b1;
    m_count    = '0;
    m_waddr    = '0;
    m_wdata    = '0;
    m_pc       = '0;
    exp_q.delete();
  endtask

  task automatic rand_data();
    ip_wb_dst     = 5'($urandom_range(0, 31));
    lsp_wb_dst    = 5'($urandom_range(0, 31));
    md_wb_dst     = 5'($urandom_range(0, 31));
    ip_wb_result  = {$urandom, $urandom};
    lsp_wb_result = {$urandom, $urandom};
    md_wb_result  = {$urandom, $urandom};
    ip_wb_pc      = {$urandom, $urandom};
    lsp_wb_pc     = {$urandom, $urandom};
    md_wb_pc      = {$urandom, $urandom};
    ip_wb_wb_en   = 1'($urandom_range(0, 1));
    lsp_wb_wb_en  = 1'($urandom_range(0, 1));
    md_wb_wb_en   = 1'($urandom_range(0, 1));
  endtask

  task automatic set_v(input logic iv, input logic lv, input logic mv);
    ip_wb_valid  = iv;
    lsp_wb_valid = lv;
    md_wb_valid  = mv;
  endtask

  // One clock: predict and check ready, push expectation, then check outputs.
  task automatic cycle();
    logic    e_ip, e_lsp, e_md;
    bit      hold;
    wb_exp_t e;
    #2;
    e_ip  = 1'b0;
    e_lsp = 1'b0;
    e_md  = 1'b0;
    if (!rst) begin
      hold = (m_lsp_wait == Limit) || (m_md_wait == Limit);
      if (ip_wb_valid && !hold) e_ip = 1'b1;
      else if (lsp_wb_valid && (!md_wb_valid || m_rr_lsp)) e_lsp = 1'b1;
      else if (md_wb_valid) e_md = 1'b1;
    end
    last_rdy = {ip_wb_ready, lsp_wb_ready, md_wb_ready};
    check_eq("ready", 64'(last_rdy), 64'({e_ip, e_lsp, e_md}));

    if (rst) begin
      model_reset();
    end else begin
      if (e_ip)
        exp_q.push_back({ip_wb_wb_en && (ip_wb_dst != 5'd0), ip_wb_dst, ip_wb_result, ip_wb_pc});
      if (e_lsp)
        exp_q.push_back({lsp_wb_wb_en && (lsp_wb_dst != 5'd0), lsp_wb_dst, lsp_wb_result,
                         lsp_wb_pc});
      if (e_md)
        exp_q.push_back({md_wb_wb_en && (md_wb_dst != 5'd0), md_wb_dst, md_wb_result, md_wb_pc});
      m_lsp_wait = (!lsp_wb_valid || e_lsp) ? 0 :
                   ((m_lsp_wait == Limit) ? Limit : m_lsp_wait + 1);
      m_md_wait  = (!md_wb_valid || e_md) ? 0 :
                   ((m_md_wait == Limit) ? Limit : m_md_wait + 1);
      if (e_lsp) m_rr_lsp = 1'b0;
      else if (e_md) m_rr_lsp = 1'b1;
    end

    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e       = exp_q.pop_front();
      m_count = m_count + 64'd1;
      m_waddr = e.waddr;
      m_wdata = e.wdata;
      m_pc    = e.pc;
      check_eq("trace_valid", 64'(wb_trace_valid), 64'd1);
      check_eq("rf_wen", 64'(rf_wen), 64'(e.wen));
    end else begin
      check_eq("trace_valid_idle", 64'(wb_trace_valid), 64'd0);
      check_eq("rf_wen_idle", 64'(rf_wen), 64'd0);
    end
    check_eq("rf_waddr", 64'(rf_waddr), 64'(m_waddr));
    check_eq("rf_wdata", rf_wdata, m_wdata);
    check_eq("trace_pc", wb_trace_pc, m_pc);
    check_eq("retire_count", wb_retire_count, m_count);
  endtask

  initial begin
    model_reset();
    last_rdy = '0;
    rst = 1'b1;
    rand_data();
    set_v(1'b1, 1'b1, 1'b1);
    cycle();
    cycle();
    check_eq("reset_ready", 64'(last_rdy), 64'd0);

    // Single ip writeback
    rst = 1'b0;
    rand_data();
    set_v(1'b1, 1'b0, 1'b0);
    ip_wb_dst    = 5'd5;
    ip_wb_result = 64'h1234;
    ip_wb_wb_en  = 1'b1;
    cycle();
    check_eq("ip_ready", 64'(last_rdy), 64'b100);
    check_eq("ip_rf_wen", 64'(rf_wen), 64'd1);
    check_eq("ip_rf_waddr", 64'(rf_waddr), 64'd5);
    check_eq("ip_rf_wdata", rf_wdata, 64'h1234);
    check_eq("ip_count", wb_retire_count, 64'd1);

    // lsp/md alternate when both valid
    for (int i = 0; i < 4; i++) begin
      rand_data();
      set_v(1'b0, 1'b1, 1'b1);
      cycle();
      check_eq($sformatf("rr_grant%0d", i), 64'(last_rdy), (i % 2 == 0) ? 64'b010 : 64'b001);
    end
    check_eq("rr_count", wb_retire_count, 64'd5);

    // md starved by ip until its wait counter saturates
    set_v(1'b0, 1'b0, 1'b0);
    cycle();
    for (int i = 0; i < 6; i++) begin
      rand_data();
      set_v(1'b1, 1'b0, 1'b1);
      cycle();
      check_eq($sformatf("starve%0d", i), 64'(last_rdy), (i == 4) ? 64'b001 : 64'b100);
    end

    // md to x0: traced, not written
    rand_data();
    set_v(1'b0, 1'b0, 1'b1);
    md_wb_dst   = 5'd0;
    md_wb_wb_en = 1'b1;
    md_wb_pc    = 64'hCAFE_0000_BEEF_0040;
    cycle();
    check_eq("x0_wen", 64'(rf_wen), 64'd0);
    check_eq("x0_trace_valid", 64'(wb_trace_valid), 64'd1);
    check_eq("x0_trace_pc", wb_trace_pc, 64'hCAFE_0000_BEEF_0040);

    // Retire counter wrap
    set_v(1'b0, 1'b0, 1'b0);
    force dut.retire_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.retire_q;
    m_count = 64'hFFFF_FFFF_FFFF_FFFF;
    rand_data();
    set_v(1'b1, 1'b0, 1'b0);
    cycle();
    check_eq("wrap_count", wb_retire_count, 64'd0);

    // Reset mid-stream with ip valid
    rand_data();
    set_v(1'b1, 1'b1, 1'b1);
    rst = 1'b1;
    cycle();
    check_eq("rst_ready", 64'(last_rdy), 64'd0);
    check_eq("rst_trace_valid", 64'(wb_trace_valid), 64'd0);
    check_eq("rst_count", wb_retire_count, 64'd0);
    check_eq("rst_wdata", rf_wdata, 64'd0);
    rst = 1'b0;

    // Random traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      rand_data();
      set_v(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
      rst = ($urandom_range(0, 59) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have a single clock; reset is synchronous and active-high.
REQ-002 SHALL provide parameter STARVE_LIMIT, default 4, meaning consecutive lost-grant cycles before the integer pipe is held off.
REQ-003 clk  input  1  clock.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 ip_wb_dst / lsp_wb_dst / md_wb_dst  input  5 each  destination register per source.
REQ-006 ip_wb_result / lsp_wb_result / md_wb_result  input  64 each  result data.
REQ-007 ip_wb_pc / lsp_wb_pc / md_wb_pc  input  64 each  instruction PC.
REQ-008 ip_wb_wb_en / lsp_wb_wb_en / md_wb_wb_en  input  1 each  register write requested.
REQ-009 ip_wb_valid / lsp_wb_valid / md_wb_valid  input  1 each  source holds a completed instruction.
REQ-010 ip_wb_ready / lsp_wb_ready / md_wb_ready  output  1 each  source accepted this cycle.
REQ-011 rf_wen  output  1  register file write enable.
REQ-012 rf_waddr  output  5  register file write address.
REQ-013 rf_wdata  output  64  register file write data.
REQ-014 wb_trace_valid  output  1  one instruction retired.
REQ-015 wb_trace_pc  output  64  PC of retired instruction.
REQ-016 wb_retire_count  output  64  total retired instructions.

Function
REQ-017 SHALL accept at most one source per cycle; a transfer occurs when x_wb_valid and x_wb_ready are both high.
REQ-018 x_wb_ready SHALL be combinational, high only for the granted source, and low for any source whose valid is low.
REQ-019 Grant SHALL go to ip when ip_wb_valid and ip is not held off; otherwise to lsp or md.
REQ-020 Between lsp and md, grant SHALL be round-robin: when both are valid, the one not granted most recently wins; a single valid one wins unconditionally.
REQ-021 The round-robin pointer SHALL update only on an lsp or md transfer.
REQ-022 A per-source wait counter (lsp, md) SHALL increment each cycle the source is valid and not granted, and clear on its transfer or when its valid is low; it saturates at STARVE_LIMIT.
REQ-023 When either wait counter equals STARVE_LIMIT, ip SHALL be held off (ip_wb_ready low) that cycle and lsp/md arbitration applies.
REQ-024 Latency SHALL be one cycle: a transfer in cycle N drives rf_*, wb_trace_* in cycle N+1 from registers.
REQ-025 rf_wen SHALL be 1 only when the transferred instruction had wb_en=1 and dst!=0; rf_waddr/rf_wdata hold captured dst/result.
REQ-026 wb_trace_valid SHALL be 1 for every transfer, regardless of wb_en or dst; wb_trace_pc holds its PC.
REQ-027 wb_retire_count SHALL increment by 1 in the cycle wb_trace_valid is registered high; it wraps from 2^64-1 to 0.
REQ-028 With no transfer, rf_wen and wb_trace_valid SHALL be 0 next cycle; rf_waddr, rf_wdata, wb_trace_pc hold their last values.
REQ-029 A source dropping valid without a transfer SHALL cause no state change besides clearing its wait counter.

Reset
REQ-030 On rst: rf_wen=0, rf_waddr=0, rf_wdata=0, wb_trace_valid=0, wb_trace_pc=0, wb_retire_count=0, wait counters=0, round-robin pointer favours lsp.
REQ-031 During rst all x_wb_ready SHALL be 0; a transfer pending in the reset cycle is dropped.
REQ-032 Reset asserted mid-stream SHALL take effect on the next edge, overriding any capture that cycle.

Verification
REQ-033 Reset, then ip valid dst=5 result=0x1234 wb_en=1 -> ip_wb_ready=1 same cycle; next cycle rf_wen=1, rf_waddr=5, rf_wdata=0x1234, retire_count=1.
REQ-034 lsp and md valid together for 4 cycles, ip idle -> grants lsp, md, lsp, md; retire_count advances by 4.
REQ-035 ip valid continuously, md valid from cycle 0 -> md ungranted cycles 0-3, ip_wb_ready=0 in cycle 4, md transfers in cycle 4.
REQ-036 md valid dst=0 wb_en=1 -> next cycle rf_wen=0, wb_trace_valid=1, trace_pc equals md_wb_pc.
REQ-037 retire_count preloaded by 2^64-1 transfers (forced) plus one transfer -> retire_count=0.
REQ-038 rst asserted in a cycle with ip valid -> ip_wb_ready=0, next cycle all outputs zero, retire_count=0.
